// File: rtl/uart_tx_packet_arbiter_if.sv
// Packet-source side of the UART transmit arbiter: level request, grant and a
// byte stream per channel ({ch1, ch0} packing).
interface uart_tx_packet_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [15:0] s_data;
  logic [1:0]  s_valid;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;

  modport master (
    output req, s_data, s_valid, s_last,
    input  grant, s_ready
  );

  modport slave (
    input  req, s_data, s_valid, s_last,
    output grant, s_ready
  );
endinterface

// File: rtl/uart_tx_packet_arbiter.sv
// Packet-granular arbiter sharing one uart_tx between the frame streamer (ch0)
// and the telemetry source (ch1), with a per-grant stall watchdog.
module uart_tx_packet_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter bit          STRICT_PRIO = 1'b0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                        clk_uart,
  input  logic                        rst_n,
  uart_tx_packet_arbiter_if.slave     pkt,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [1:0]                  timeout_pulse,
  output logic [CNT_WIDTH-1:0]        pkt_cnt0,
  output logic [CNT_WIDTH-1:0]        pkt_cnt1
);

  localparam int unsigned     WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t                state, state_n;
  logic [1:0]            grant_q, grant_n;
  logic                  last_served, last_served_n;
  logic [WD_W-1:0]       wd_cnt, wd_cnt_n;
  logic                  last_flag, last_flag_n;
  logic                  tx_start_n;
  logic [7:0]            tx_data_n;
  logic [1:0]            timeout_n;
  logic [CNT_WIDTH-1:0]  pkt_cnt0_n, pkt_cnt1_n;

  // grant is one-hot whenever it is used as an index, so bit 1 names the channel
  logic       gsel;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;
  logic       sel_req;

  assign gsel      = grant_q[1];
  assign sel_data  = gsel ? pkt.s_data[15:8] : pkt.s_data[7:0];
  assign sel_valid = pkt.s_valid[gsel];
  assign sel_last  = pkt.s_last[gsel];
  assign sel_req   = pkt.req[gsel];

  assign pkt.grant   = grant_q;
  assign pkt.s_ready = (state == SEND) ? grant_q : '0;

  always_comb begin
    state_n       = state;
    grant_n       = grant_q;
    last_served_n = last_served;
    wd_cnt_n      = wd_cnt;
    last_flag_n   = last_flag;
    tx_start_n    = 1'b0;
    tx_data_n     = tx_data;
    timeout_n     = '0;
    pkt_cnt0_n    = pkt_cnt0;
    pkt_cnt1_n    = pkt_cnt1;

    unique case (state)
      IDLE: begin
        if (!tx_busy && (pkt.req != 2'b00)) begin
          state_n  = SEND;
          wd_cnt_n = '0;
          if (pkt.req == 2'b11) begin
            // Tie: strict mode favours ch0, otherwise the channel not served last
            grant_n = (STRICT_PRIO || last_served) ? 2'b01 : 2'b10;
          end else begin
            grant_n = pkt.req;
          end
        end
      end

      SEND: begin
        if (!sel_req) begin
          state_n       = IDLE;
          grant_n       = '0;
          last_served_n = gsel;
        end else if (sel_valid) begin
          tx_data_n   = sel_data;
          tx_start_n  = 1'b1;
          last_flag_n = sel_last;
          wd_cnt_n    = '0;
          state_n     = WAIT_DONE;
        end else if (TIMEOUT_CYC != 0) begin
          if (wd_cnt == WD_MAX) begin
            timeout_n     = grant_q;
            grant_n       = '0;
            last_served_n = gsel;
            state_n       = IDLE;
          end else begin
            wd_cnt_n = wd_cnt + 1'b1;
          end
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
          if (last_flag) begin
            if (gsel) pkt_cnt1_n = pkt_cnt1 + 1'b1;
            else      pkt_cnt0_n = pkt_cnt0 + 1'b1;
            grant_n       = '0;
            last_served_n = gsel;
            state_n       = IDLE;
          end else if (!sel_req) begin
            grant_n       = '0;
            last_served_n = gsel;
            state_n       = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_q       <= '0;
      last_served   <= 1'b1;
      wd_cnt        <= '0;
      last_flag     <= 1'b0;
      tx_start      <= 1'b0;
      tx_data       <= 8'h00;
      timeout_pulse <= '0;
      pkt_cnt0      <= '0;
      pkt_cnt1      <= '0;
    end else begin
      state         <= state_n;
      grant_q       <= grant_n;
      last_served   <= last_served_n;
      wd_cnt        <= wd_cnt_n;
      last_flag     <= last_flag_n;
      tx_start      <= tx_start_n;
      tx_data       <= tx_data_n;
      timeout_pulse <= timeout_n;
      pkt_cnt0      <= pkt_cnt0_n;
      pkt_cnt1      <= pkt_cnt1_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Directed bench for uart_tx_packet_arbiter: a round-robin instance with an
// 8-cycle watchdog and a strict-priority instance, each with a uart_tx model.
module tb_uart_tx_packet_arbiter;
  logic clk_uart = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_uart = ~clk_uart;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: round-robin, TIMEOUT_CYC = 8
  uart_tx_packet_arbiter_if pkt();
  logic        req0, req1, val0, val1, last0, last1;
  logic [7:0]  dat0, dat1;
  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_data;
  logic [1:0]  timeout_pulse;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  assign pkt.req     = {req1, req0};
  assign pkt.s_valid = {val1, val0};
  assign pkt.s_last  = {last1, last0};
  assign pkt.s_data  = {dat1, dat0};

  uart_tx_packet_arbiter #(.TIMEOUT_CYC(8), .STRICT_PRIO(1'b0), .CNT_WIDTH(16)) dut (
    .clk_uart(clk_uart), .rst_n(rst_n), .pkt(pkt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .timeout_pulse(timeout_pulse), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  // Instance B: strict priority, watchdog disabled
  uart_tx_packet_arbiter_if pkt_b();
  logic [1:0]  b_req, b_valid, b_last;
  logic [15:0] b_data;
  logic        b_tx_start, b_tx_busy, b_tx_done;
  logic [7:0]  b_tx_data;
  logic [1:0]  b_timeout;
  logic [15:0] b_cnt0, b_cnt1;

  assign pkt_b.req     = b_req;
  assign pkt_b.s_valid = b_valid;
  assign pkt_b.s_last  = b_last;
  assign pkt_b.s_data  = b_data;

  uart_tx_packet_arbiter #(.TIMEOUT_CYC(0), .STRICT_PRIO(1'b1), .CNT_WIDTH(16)) dut_b (
    .clk_uart(clk_uart), .rst_n(rst_n), .pkt(pkt_b),
    .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy), .tx_done(b_tx_done),
    .timeout_pulse(b_timeout), .pkt_cnt0(b_cnt0), .pkt_cnt1(b_cnt1)
  );

  // Source queues: bit 8 marks the last byte of a packet
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit stall0 = 1'b0;
  bit stall1 = 1'b0;
  int done_delay = 5;

  logic [9:0] log_a[$];
  logic [9:0] log_b[$];
  int to_seen = 0;

  initial begin : src0
    bit hs;
    req0 = 1'b0; val0 = 1'b0; last0 = 1'b0; dat0 = 8'h00;
    forever begin
      @(negedge clk_uart);
      hs = val0 && pkt.s_ready[0];
      @(posedge clk_uart); #1;
      if (hs && q0.size() != 0) q0.delete(0);
      if (q0.size() != 0) begin
        req0 = 1'b1; val0 = !stall0; dat0 = q0[0][7:0]; last0 = q0[0][8];
      end else begin
        req0 = 1'b0; val0 = 1'b0; dat0 = 8'h00; last0 = 1'b0;
      end
    end
  end

  initial begin : src1
    bit hs;
    req1 = 1'b0; val1 = 1'b0; last1 = 1'b0; dat1 = 8'h00;
    forever begin
      @(negedge clk_uart);
      hs = val1 && pkt.s_ready[1];
      @(posedge clk_uart); #1;
      if (hs && q1.size() != 0) q1.delete(0);
      if (q1.size() != 0) begin
        req1 = 1'b1; val1 = !stall1; dat1 = q1[0][7:0]; last1 = q1[0][8];
      end else begin
        req1 = 1'b0; val1 = 1'b0; dat1 = 8'h00; last1 = 1'b0;
      end
    end
  end

  initial begin : uart_model_a
    int cnt;
    tx_busy = 1'b0; tx_done = 1'b0; cnt = 0;
    forever begin
      @(posedge clk_uart); #1;
      tx_done = 1'b0;
      if (!rst_n) begin
        tx_busy = 1'b0; cnt = 0;
      end else if (tx_start) begin
        tx_busy = 1'b1; cnt = done_delay;
      end else if (tx_busy) begin
        cnt--;
        if (cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; end
      end
    end
  end

  initial begin : uart_model_b
    int cnt;
    b_tx_busy = 1'b0; b_tx_done = 1'b0; cnt = 0;
    forever begin
      @(posedge clk_uart); #1;
      b_tx_done = 1'b0;
      if (!rst_n) begin
        b_tx_busy = 1'b0; cnt = 0;
      end else if (b_tx_start) begin
        b_tx_busy = 1'b1; cnt = 3;
      end else if (b_tx_busy) begin
        cnt--;
        if (cnt == 0) begin b_tx_busy = 1'b0; b_tx_done = 1'b1; end
      end
    end
  end

  always @(negedge clk_uart) begin
    if (tx_start)   log_a.push_back({pkt.grant, tx_data});
    if (b_tx_start) log_b.push_back({pkt_b.grant, b_tx_data});
    if (timeout_pulse != 2'b00) to_seen++;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    b_req = 2'b00; b_valid = 2'b00; b_last = 2'b00; b_data = 16'h0000;
    repeat (2) @(negedge clk_uart);
    n_checks++;
    if ({pkt.grant, pkt.s_ready, tx_start, tx_data, timeout_pulse} !== 15'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h",
               {pkt.grant, pkt.s_ready, tx_start, tx_data, timeout_pulse}, 15'h0000);
    end
    n_checks++;
    if ({pkt_cnt0, pkt_cnt1} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected %h", {pkt_cnt0, pkt_cnt1}, 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_uart);
    n_checks++;
    if ({pkt.grant, tx_start} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_release: got %b expected %b", {pkt.grant, tx_start}, 3'b000);
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] exp [8];
    logic [9:0] got;
    int base;
    exp = '{10'h110, 10'h111, 10'h220, 10'h221, 10'h112, 10'h113, 10'h222, 10'h223};
    base = log_a.size();
    done_delay = 5;
    q0.push_back(9'h010); q0.push_back(9'h111); q0.push_back(9'h012); q0.push_back(9'h113);
    q1.push_back(9'h020); q1.push_back(9'h121); q1.push_back(9'h022); q1.push_back(9'h123);
    for (int i = 0; i < 600 && !(pkt_cnt0 == 16'd2 && pkt_cnt1 == 16'd2); i++) @(negedge clk_uart);
    repeat (2) @(negedge clk_uart);
    n_checks++;
    if ({pkt_cnt0, pkt_cnt1} !== {16'd2, 16'd2}) begin
      n_fail++; $display("FAIL rr_counts: got %h expected %h", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2});
    end
    for (int i = 0; i < 8; i++) begin
      got = (base + i < log_a.size()) ? log_a[base + i] : 10'h3FF;
      n_checks++;
      if (got !== exp[i]) begin
        n_fail++; $display("FAIL rr_byte%0d: got %h expected %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_single_packet();
    logic [9:0] exp [3];
    logic [9:0] got;
    logic [15:0] c0;
    int base;
    exp = '{10'h1A5, 10'h15A, 10'h1F0};
    base = log_a.size();
    c0 = pkt_cnt0;
    done_delay = 20;
    q0.push_back(9'h0A5); q0.push_back(9'h05A); q0.push_back(9'h1F0);
    @(negedge clk_uart);
    n_checks++;
    if (pkt.grant !== 2'b00) begin
      n_fail++; $display("FAIL sp_no_grant_yet: got %b expected %b", pkt.grant, 2'b00);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({pkt.grant, pkt.s_ready, tx_start} !== 5'b01_01_0) begin
      n_fail++; $display("FAIL sp_grant_latency: got %b expected %b", {pkt.grant, pkt.s_ready, tx_start}, 5'b01010);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({pkt.s_ready, tx_start, tx_data} !== {2'b00, 1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL sp_first_start: got %h expected %h", {pkt.s_ready, tx_start, tx_data}, {2'b00, 1'b1, 8'hA5});
    end
    for (int i = 0; i < 200 && !(tx_done && log_a.size() == base + 3); i++) @(negedge clk_uart);
    n_checks++;
    if ({tx_done, pkt.grant} !== 3'b1_01) begin
      n_fail++; $display("FAIL sp_final_done: got %b expected %b", {tx_done, pkt.grant}, 3'b101);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({pkt.grant, pkt_cnt0} !== {2'b00, 16'(c0 + 16'd1)}) begin
      n_fail++; $display("FAIL sp_release: got %h expected %h", {pkt.grant, pkt_cnt0}, {2'b00, 16'(c0 + 16'd1)});
    end
    for (int i = 0; i < 3; i++) begin
      got = (base + i < log_a.size()) ? log_a[base + i] : 10'h3FF;
      n_checks++;
      if (got !== exp[i]) begin
        n_fail++; $display("FAIL sp_byte%0d: got %h expected %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp [5];
    logic [9:0] got;
    int base;
    exp = '{10'h130, 10'h131, 10'h132, 10'h133, 10'h240};
    base = log_a.size();
    done_delay = 5;
    q0.push_back(9'h030); q0.push_back(9'h031); q0.push_back(9'h032); q0.push_back(9'h133);
    for (int i = 0; i < 100 && log_a.size() < base + 2; i++) @(negedge clk_uart);
    q1.push_back(9'h140);
    for (int i = 0; i < 200 && !(tx_done && log_a.size() == base + 4); i++) @(negedge clk_uart);
    @(negedge clk_uart);
    n_checks++;
    if (pkt.grant !== 2'b00) begin
      n_fail++; $display("FAIL mc_gap_idle: got %b expected %b", pkt.grant, 2'b00);
    end
    @(negedge clk_uart);
    n_checks++;
    if (pkt.grant !== 2'b10) begin
      n_fail++; $display("FAIL mc_ch1_grant: got %b expected %b", pkt.grant, 2'b10);
    end
    for (int i = 0; i < 100 && log_a.size() < base + 5; i++) @(negedge clk_uart);
    for (int i = 0; i < 5; i++) begin
      got = (base + i < log_a.size()) ? log_a[base + i] : 10'h3FF;
      n_checks++;
      if (got !== exp[i]) begin
        n_fail++; $display("FAIL mc_byte%0d: got %h expected %h", i, got, exp[i]);
      end
    end
    repeat (10) @(negedge clk_uart);
  endtask

  task automatic test_watchdog();
    logic [15:0] c1;
    logic [9:0]  got0, got1;
    int base, to0;
    bit ok;
    base = log_a.size(); to0 = to_seen; c1 = pkt_cnt1;
    stall1 = 1'b1;
    q1.push_back(9'h150);
    for (int i = 0; i < 20 && pkt.grant !== 2'b10; i++) @(negedge clk_uart);
    n_checks++;
    if (pkt.grant !== 2'b10) begin
      n_fail++; $display("FAIL wd_grant: got %b expected %b", pkt.grant, 2'b10);
    end
    q0.push_back(9'h160);
    ok = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_uart);
      if (pkt.grant !== 2'b10 || timeout_pulse !== 2'b00) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL wd_hold: got %b expected %b", ok, 1'b1);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({timeout_pulse, pkt.grant} !== 4'b10_00) begin
      n_fail++; $display("FAIL wd_pulse: got %b expected %b", {timeout_pulse, pkt.grant}, 4'b1000);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({timeout_pulse, pkt.grant} !== 4'b00_01) begin
      n_fail++; $display("FAIL wd_next_ch0: got %b expected %b", {timeout_pulse, pkt.grant}, 4'b0001);
    end
    stall1 = 1'b0;
    for (int i = 0; i < 100 && pkt_cnt1 != 16'(c1 + 16'd1); i++) @(negedge clk_uart);
    got0 = (base < log_a.size())     ? log_a[base]     : 10'h3FF;
    got1 = (base + 1 < log_a.size()) ? log_a[base + 1] : 10'h3FF;
    n_checks++;
    if ({got0, got1} !== {10'h160, 10'h250}) begin
      n_fail++; $display("FAIL wd_order: got %h expected %h", {got0, got1}, {10'h160, 10'h250});
    end
    n_checks++;
    if (to_seen !== to0 + 1) begin
      n_fail++; $display("FAIL wd_pulse_count: got %0d expected %0d", to_seen, to0 + 1);
    end
    repeat (5) @(negedge clk_uart);
  endtask

  task automatic test_abort();
    logic [15:0] c0;
    logic [9:0]  got;
    int base;
    bit ok;
    base = log_a.size(); c0 = pkt_cnt0;
    q0.push_back(9'h070); q0.push_back(9'h071); q0.push_back(9'h172);
    for (int i = 0; i < 20 && tx_start !== 1'b1; i++) @(negedge clk_uart);
    q0.delete();
    ok = 1'b1;
    for (int i = 0; i < 40 && tx_done !== 1'b1; i++) begin
      @(negedge clk_uart);
      if (pkt.grant !== 2'b01) ok = 1'b0;
    end
    n_checks++;
    if ({ok, tx_done} !== 2'b11) begin
      n_fail++; $display("FAIL ab_byte_completes: got %b expected %b", {ok, tx_done}, 2'b11);
    end
    @(negedge clk_uart);
    n_checks++;
    if ({pkt.grant, pkt_cnt0} !== {2'b00, c0}) begin
      n_fail++; $display("FAIL ab_idle_nocount: got %h expected %h", {pkt.grant, pkt_cnt0}, {2'b00, c0});
    end
    repeat (30) @(negedge clk_uart);
    got = (base < log_a.size()) ? log_a[base] : 10'h3FF;
    n_checks++;
    if ({got, 8'(log_a.size() - base)} !== {10'h170, 8'd1}) begin
      n_fail++; $display("FAIL ab_single_byte: got %h expected %h", {got, 8'(log_a.size() - base)}, {10'h170, 8'd1});
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [9:0] got0, got1;
    int base;
    q0.push_back(9'h080); q0.push_back(9'h181);
    for (int i = 0; i < 20 && tx_start !== 1'b1; i++) @(negedge clk_uart);
    repeat (2) @(negedge clk_uart);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    n_checks++;
    if ({pkt.grant, pkt.s_ready, tx_start, tx_data, timeout_pulse, pkt_cnt0, pkt_cnt1} !== 47'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected %h",
               {pkt.grant, pkt.s_ready, tx_start, tx_data, timeout_pulse, pkt_cnt0, pkt_cnt1}, 47'h0);
    end
    repeat (3) @(negedge clk_uart);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_uart);
    base = log_a.size();
    q0.push_back(9'h190); q1.push_back(9'h191);
    for (int i = 0; i < 100 && !(pkt_cnt0 == 16'd1 && pkt_cnt1 == 16'd1); i++) @(negedge clk_uart);
    got0 = (base < log_a.size())     ? log_a[base]     : 10'h3FF;
    got1 = (base + 1 < log_a.size()) ? log_a[base + 1] : 10'h3FF;
    n_checks++;
    if ({got0, got1} !== {10'h190, 10'h291}) begin
      n_fail++; $display("FAIL rst_tie_ch0: got %h expected %h", {got0, got1}, {10'h190, 10'h291});
    end
  endtask

  task automatic test_strict_prio();
    logic [9:0] got;
    int n;
    b_data = {8'hB1, 8'hB0}; b_valid = 2'b11; b_last = 2'b11; b_req = 2'b11;
    for (int i = 0; i < 200 && !(b_tx_start && log_b.size() >= 4); i++) @(negedge clk_uart);
    for (int i = 0; i < 4; i++) begin
      got = (i < log_b.size()) ? log_b[i] : 10'h3FF;
      n_checks++;
      if (got !== 10'h1B0) begin
        n_fail++; $display("FAIL sp_prio_ch0_%0d: got %h expected %h", i, got, 10'h1B0);
      end
    end
    b_req = 2'b10;
    @(negedge clk_uart);
    n = log_b.size();
    for (int i = 0; i < 50 && log_b.size() < n + 1; i++) @(negedge clk_uart);
    got = (n < log_b.size()) ? log_b[n] : 10'h3FF;
    n_checks++;
    if (got !== 10'h2B1) begin
      n_fail++; $display("FAIL sp_prio_ch1_after_drop: got %h expected %h", got, 10'h2B1);
    end
    n_checks++;
    if ({b_cnt0, b_cnt1} !== {16'(n), 16'd0}) begin
      n_fail++; $display("FAIL sp_prio_counts: got %h expected %h", {b_cnt0, b_cnt1}, {16'(n), 16'd0});
    end
    b_req = 2'b00; b_valid = 2'b00;
    repeat (10) @(negedge clk_uart);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_packet();
    test_contention();
    test_watchdog();
    test_abort();
    test_reset_mid_packet();
    test_strict_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "time limit reached");
  end

endmodule
